// File: rtl/misao_mem_responder.sv
// Byte memory responder for the misao core: zero-fills, accepts a program image,
// then serves combinational reads and clocked writes while holding the core out of reset.
module misao_mem_responder #(
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        core_rst,
  input  logic        mem_enable_read,
  input  logic        mem_enable_write,
  input  logic [14:0] mem_addr,
  input  logic        mem_rw,
  input  logic [7:0]  mem_data_out,
  output logic [7:0]  mem_data_in,
  output logic        loaded,
  output logic [15:0] write_count,
  output logic        addr_fault
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx_s;
  logic [ADDR_W-1:0] ptr_r;
  logic [ADDR_W-1:0] ptr_nx_s;
  logic [ADDR_W-1:0] ptr_inc_s;
  logic [7:0]        mem_r [DEPTH];
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_wa_s;
  logic [7:0]        mem_wd_s;
  logic [7:0]        rd_data_s;
  logic              in_range_s;
  logic              core_rst_r;
  logic              loaded_r;
  logic [15:0]       write_count_r;
  logic              addr_fault_r;
  logic              unused_rw_s;

  // The direction hint carries no information beyond the two enable strobes.
  assign unused_rw_s = mem_rw;
  assign ptr_inc_s   = ptr_r + PTR_ONE;
  assign rd_data_s   = mem_r[mem_addr[ADDR_W-1:0]];

  // Any set bit above the memory size means the access lies outside DEPTH.
  generate
    if (ADDR_W < 15) begin : g_range
      assign in_range_s = ~|mem_addr[14:ADDR_W];
    end else begin : g_full
      assign in_range_s = 1'b1;
    end
  endgenerate

  // Next-state, pointer and memory write-port selection.
  always_comb begin
    state_nx_s = state_r;
    ptr_nx_s   = ptr_r;
    mem_we_s   = 1'b0;
    mem_wa_s   = ptr_r;
    mem_wd_s   = 8'h00;
    case (state_r)
      ST_CLEAR: begin
        mem_we_s = 1'b1;
        if (ptr_r == PTR_LAST) begin
          state_nx_s = ST_LOAD;
          ptr_nx_s   = PTR_ZERO;
        end else begin
          state_nx_s = ST_CLEAR;
          ptr_nx_s   = ptr_inc_s;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          mem_we_s = 1'b1;
          mem_wd_s = load_data;
          ptr_nx_s = ptr_inc_s;
          // Stopping on the last slot keeps an oversize image from wrapping onto address 0.
          if (load_last || (ptr_r == PTR_LAST)) begin
            state_nx_s = ST_RUN;
          end else begin
            state_nx_s = ST_LOAD;
          end
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        mem_we_s   = mem_enable_write & in_range_s;
        mem_wa_s   = mem_addr[ADDR_W-1:0];
        mem_wd_s   = mem_data_out;
        state_nx_s = ST_RUN;
      end
      default: begin
        state_nx_s = ST_CLEAR;
        ptr_nx_s   = PTR_ZERO;
      end
    endcase
  end

  // State, pointer and status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_CLEAR;
      ptr_r         <= PTR_ZERO;
      core_rst_r    <= 1'b1;
      loaded_r      <= 1'b0;
      write_count_r <= 16'h0000;
      addr_fault_r  <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      ptr_r      <= ptr_nx_s;
      core_rst_r <= (state_nx_s != ST_RUN);
      loaded_r   <= (state_nx_s == ST_RUN);
      if ((state_r == ST_RUN) && mem_enable_write && in_range_s &&
          (write_count_r != 16'hFFFF)) begin
        write_count_r <= write_count_r + 16'h0001;
      end
      if ((state_r == ST_RUN) && (mem_enable_read || mem_enable_write) && !in_range_s) begin
        addr_fault_r <= 1'b1;
      end
    end
  end

  // Memory array; reset leaves contents alone, CLEAR overwrites them.
  always_ff @(posedge clk) begin
    if (rst && mem_we_s) begin
      mem_r[mem_wa_s] <= mem_wd_s;
    end
  end

  // Combinational read path and load handshake.
  always_comb begin
    mem_data_in = 8'h00;
    load_ready  = 1'b0;
    if (rst && (state_r == ST_RUN) && in_range_s) begin
      mem_data_in = rd_data_s;
    end else begin
      mem_data_in = 8'h00;
    end
    if (rst && (state_r == ST_LOAD)) begin
      load_ready = 1'b1;
    end else begin
      load_ready = 1'b0;
    end
  end

  assign core_rst    = core_rst_r;
  assign loaded      = loaded_r;
  assign write_count = write_count_r;
  assign addr_fault  = addr_fault_r;

endmodule

// File: tb/tb_misao_mem_responder.sv
// Directed bench for misao_mem_responder with a reference memory and expectation queue.
module tb_misao_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = 8'h00;
  logic        load_last = 1'b0;
  logic        load_ready;
  logic        core_rst;
  logic        mem_enable_read = 1'b0;
  logic        mem_enable_write = 1'b0;
  logic [14:0] mem_addr = 15'h0000;
  logic        mem_rw = 1'b0;
  logic [7:0]  mem_data_out = 8'h00;
  logic [7:0]  mem_data_in;
  logic        loaded;
  logic [15:0] write_count;
  logic        addr_fault;

  misao_mem_responder #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
    .load_ready(load_ready), .core_rst(core_rst),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_addr(mem_addr), .mem_rw(mem_rw), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .loaded(loaded),
    .write_count(write_count), .addr_fault(addr_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] tb_mem [256];
  int         tb_ptr;
  int         vectors = 0;
  int         errors = 0;

  task automatic expect_val(input string tag, input logic [15:0] e);
    exp_t item;
    item.tag = tag;
    item.exp = e;
    sb_q.push_back(item);
  endtask

  task automatic check_obs(input logic [15:0] obs);
    exp_t item;
    vectors++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h with no expectation", obs);
    end else begin
      item = sb_q.pop_front();
      assert (obs === item.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] e);
    expect_val(tag, e);
    check_obs(obs);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    mem_enable_read = 1'b0;
    mem_enable_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst", {15'd0, core_rst}, 16'd1);
    chk("rst_loaded", {15'd0, loaded}, 16'd0);
    chk("rst_load_ready", {15'd0, load_ready}, 16'd0);
    chk("rst_write_count", write_count, 16'd0);
    chk("rst_addr_fault", {15'd0, addr_fault}, 16'd0);
    chk("rst_data_in", {8'd0, mem_data_in}, 16'd0);
    rst = 1'b1;
  endtask

  // Counts edges until load_ready rises; the core must stay in reset throughout.
  task automatic wait_clear();
    int n;
    logic held;
    n = 0;
    held = 1'b1;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (core_rst !== 1'b1) held = 1'b0;
    end while (load_ready !== 1'b1 && n < 1000);
    chk("clear_edges", n[15:0], 16'd256);
    chk("clear_core_rst_held", {15'd0, held}, 16'd1);
    for (int a = 0; a < 256; a++) tb_mem[a] = 8'h00;
    tb_ptr = 0;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data = d;
    load_last = last;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last = 1'b0;
    load_data = 8'hEE;
    tb_mem[tb_ptr] = d;
    tb_ptr++;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] addr);
    mem_addr = addr[14:0];
    #1;
    expect_val(tag, (addr < 16'd256) ? {8'd0, tb_mem[addr[7:0]]} : 16'd0);
    check_obs({8'd0, mem_data_in});
  endtask

  initial begin
    // Reset and zero-fill timing.
    do_reset();
    wait_clear();
    chk("load_ready_up", {15'd0, load_ready}, 16'd1);

    // Short image ending with load_last.
    load_byte(8'h00, 1'b0);
    load_byte(8'hA1, 1'b0);
    chk("load_not_yet_run", {15'd0, loaded}, 16'd0);
    load_byte(8'h5B, 1'b1);
    chk("load_core_rst", {15'd0, core_rst}, 16'd0);
    chk("load_loaded", {15'd0, loaded}, 16'd1);
    chk("run_load_ready", {15'd0, load_ready}, 16'd0);
    read_chk("rd_addr1", 16'h0001);
    read_chk("rd_addr2", 16'h0002);
    read_chk("rd_addr3_cleared", 16'h0003);

    // Core write: old data in the same cycle, new data the next.
    mem_addr = 15'h0010;
    mem_data_out = 8'h7E;
    mem_enable_write = 1'b1;
    #1;
    chk("wr_same_cycle_old", {8'd0, mem_data_in}, 16'h0000);
    @(posedge clk);
    #1;
    mem_enable_write = 1'b0;
    tb_mem[16] = 8'h7E;
    read_chk("wr_next_cycle", 16'h0010);
    chk("wr_count1", write_count, 16'd1);
    chk("wr_no_fault", {15'd0, addr_fault}, 16'd0);

    // Out-of-range read then write.
    mem_addr = 15'h0100;
    mem_enable_read = 1'b1;
    #1;
    chk("oor_rd_data", {8'd0, mem_data_in}, 16'h0000);
    chk("oor_fault_before_edge", {15'd0, addr_fault}, 16'd0);
    @(posedge clk);
    #1;
    mem_enable_read = 1'b0;
    chk("oor_fault_set", {15'd0, addr_fault}, 16'd1);
    mem_data_out = 8'h55;
    mem_enable_write = 1'b1;
    @(posedge clk);
    #1;
    mem_enable_write = 1'b0;
    chk("oor_wr_count", write_count, 16'd1);
    read_chk("oor_no_alias", 16'h0000);
    read_chk("oor_rd_high", 16'h0100);
    chk("oor_fault_sticky", {15'd0, addr_fault}, 16'd1);

    // Reset mid-load, then a fresh image must see a fully cleared memory.
    do_reset();
    wait_clear();
    for (int i = 0; i < 5; i++) load_byte(8'hC0 + i[7:0], 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_load_ready", {15'd0, load_ready}, 16'd0);
    chk("midrst_core_rst", {15'd0, core_rst}, 16'd1);
    chk("midrst_loaded", {15'd0, loaded}, 16'd0);
    rst = 1'b1;
    wait_clear();
    load_byte(8'h00, 1'b1);
    chk("midrst_run", {15'd0, loaded}, 16'd1);
    for (int a = 0; a < 256; a++) read_chk("midrst_zero", a[15:0]);

    // Stalled load: idle cycles must not advance the pointer.
    do_reset();
    wait_clear();
    load_byte(8'h11, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("stall_still_loading", {15'd0, load_ready}, 16'd1);
    load_byte(8'h22, 1'b0);
    load_byte(8'h33, 1'b1);
    chk("stall_run", {15'd0, loaded}, 16'd1);
    for (int a = 0; a < 4; a++) read_chk("stall_mem", a[15:0]);

    // Oversize image: RUN on the 256th accept, further load bytes ignored.
    do_reset();
    wait_clear();
    for (int i = 0; i < 255; i++) load_byte(i[7:0] ^ 8'h5A, 1'b0);
    chk("ovf_not_run_255", {15'd0, loaded}, 16'd0);
    load_byte(8'hFF ^ 8'h5A, 1'b0);
    chk("ovf_run_256", {15'd0, loaded}, 16'd1);
    chk("ovf_core_rst", {15'd0, core_rst}, 16'd0);
    load_valid = 1'b1;
    load_data = 8'hFF;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    read_chk("ovf_addr0", 16'h0000);
    read_chk("ovf_addr1", 16'h0001);
    read_chk("ovf_addr80", 16'h0080);
    read_chk("ovf_addr255", 16'h00FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
